// File: rtl/fpga_ram_burst_reader.sv
// Read-side burst controller for a 1-write/1-read FPGA RAM.
// A burst command (start address, word count) is turned into a stream of RAM
// read addresses. The returned words are delivered on a valid/ready stream
// with tlast. A 2-entry buffer absorbs the RAM's 1-cycle read latency, and the
// issue throttle guarantees the buffer can never overflow under backpressure.
module fpga_ram_burst_reader #(
  parameter int data_width_p    = 32,
  parameter int address_width_p = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [address_width_p-1:0] cmd_address,
  input  logic [address_width_p:0]   cmd_length,
  output logic [address_width_p-1:0] ram_address,
  input  logic [data_width_p-1:0]    ram_data,
  output logic                       tvalid,
  input  logic                       tready,
  output logic [data_width_p-1:0]    tdata,
  output logic                       tlast,
  output logic                       busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  localparam logic [address_width_p:0] REM_ZERO = {(address_width_p+1){1'b0}};
  localparam logic [address_width_p:0] REM_ONE  = {{address_width_p{1'b0}}, 1'b1};

  state_t                       state_q;
  logic [address_width_p-1:0]   addr_q;
  logic [address_width_p:0]     remaining_q;
  logic                         inflight_q;
  logic                         inflight_last_q;

  logic [data_width_p-1:0]      buf_data_q [2];
  logic                         buf_last_q [2];
  logic                         head_q;
  logic [1:0]                   count_q;
  logic [1:0]                   count_d;

  logic                         pop_s;
  logic                         issue_s;
  logic                         tail_s;
  logic [2:0]                   occupancy_s;
  logic [2:0]                   limit_s;

  // Stream-side outputs come straight from the buffer registers, so a reset
  // removes tvalid immediately without waiting for a clock edge.
  assign tvalid      = (count_q != 2'd0);
  assign tdata       = buf_data_q[head_q];
  assign tlast       = buf_last_q[head_q];
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q == READ);
  assign ram_address = addr_q;

  // Issue throttle and buffer bookkeeping: a new read may start only if the
  // words already buffered plus the one in flight, minus the one leaving now,
  // still leave a free slot for the word this read will return.
  always_comb begin
    pop_s       = (count_q != 2'd0) & tready;
    occupancy_s = {1'b0, count_q} + {2'b00, inflight_q};
    limit_s     = 3'd2 + {2'b00, pop_s};
    tail_s      = head_q ^ count_q[0];
    if ((state_q == READ) && (remaining_q != REM_ZERO) && (occupancy_s < limit_s)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    case ({inflight_q, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Burst FSM: accepts commands in IDLE, walks the address and remaining
  // counter while reading, and returns to IDLE once the tagged last word leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= {address_width_p{1'b0}};
      remaining_q     <= REM_ZERO;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          inflight_q      <= 1'b0;
          inflight_last_q <= 1'b0;
          if (cmd_valid && (cmd_length != REM_ZERO)) begin
            addr_q      <= cmd_address;
            remaining_q <= cmd_length;
            state_q     <= READ;
          end else begin
            state_q     <= IDLE;
          end
        end
        READ: begin
          if (issue_s) begin
            addr_q          <= addr_q + 1'b1;
            remaining_q     <= remaining_q - 1'b1;
            inflight_q      <= 1'b1;
            inflight_last_q <= (remaining_q == REM_ONE);
          end else begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
          end
          if (pop_s && tlast) begin
            state_q <= IDLE;
          end else begin
            state_q <= READ;
          end
        end
        default: begin
          state_q         <= IDLE;
          inflight_q      <= 1'b0;
          inflight_last_q <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output FIFO: the word returned by the RAM is written at the tail
  // in the cycle it is valid; the head advances on every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_q[0] <= {data_width_p{1'b0}};
      buf_data_q[1] <= {data_width_p{1'b0}};
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
      head_q        <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      if (inflight_q) begin
        buf_data_q[tail_s] <= ram_data;
        buf_last_q[tail_s] <= inflight_last_q;
      end
      if (pop_s) begin
        head_q <= ~head_q;
      end
      count_q <= count_d;
    end
  end

endmodule
